// File: rtl/spike_in_fifo.sv
// Spike-vector input FIFO between the serial deserializer and the neuron array.
// Writes commit one cycle after the WR_VALID pulse; head is first-word-fall-through.
module spike_in_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned SLACK = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_VALID,
  input  logic [15:0]   WR_DATA,
  output logic          BP,
  output logic          RD_VALID,
  output logic [15:0]   RD_DATA,
  input  logic          RD_READY,
  output logic [AW:0]   LEVEL,
  output logic          OVF
);

  localparam logic [AW:0]   LvlFull  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LvlOne   = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);
  localparam logic [AW+1:0] BpThresh = (AW+2)'(DEPTH - SLACK);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          bp_q, bp_d;
  logic          armed_q, armed_d;
  logic [15:0]   last_q, last_d;

  logic rd_valid;
  logic pop;
  logic full;
  logic commit;
  logic drop;

  always_comb begin
    rd_valid = (level_q != '0);
    pop      = rd_valid & RD_READY;
    full     = (level_q == LvlFull);
    // A pop in the same cycle frees the slot the pending commit needs.
    commit   = pend_q & (~full | pop);
    drop     = pend_q & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;

    if (commit) begin
      mem_d[wr_ptr_q] = WR_DATA;
      wr_ptr_d        = wr_ptr_q + PtrOne;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      last_d   = mem_q[rd_ptr_q];
    end

    if (commit && !pop) begin
      level_d = level_q + LvlOne;
    end else if (!commit && pop) begin
      level_d = level_q - LvlOne;
    end

    ovf_d   = ovf_q | drop;
    // The first edge after reset release ignores WR_VALID.
    pend_d  = WR_VALID & armed_q;
    armed_d = 1'b1;
    bp_d    = ({1'b0, level_d} + {{(AW+1){1'b0}}, pend_d}) >= BpThresh;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bp_q     <= 1'b0;
      armed_q  <= 1'b0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      bp_q     <= bp_d;
      armed_q  <= armed_d;
      last_q   <= last_d;
    end
  end

  // With the FIFO empty the output holds the most recently popped entry.
  always_comb begin
    RD_VALID = rd_valid;
    RD_DATA  = rd_valid ? mem_q[rd_ptr_q] : last_q;
    LEVEL    = level_q;
    OVF      = ovf_q;
    BP       = bp_q;
  end

endmodule

// File: tb/tb_spike_in_fifo.sv
// Bench for spike_in_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO behaviour.
module tb_spike_in_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned SLACK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [15:0]   wr_data;
  logic          bp;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic          rd_ready;
  logic [AW:0]   level;
  logic          ovf;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] mq[$];
  bit          m_pend;
  bit          m_ovf;
  bit          m_bp;
  bit          m_armed;
  logic [15:0] m_last;

  always #5 clk = ~clk;

  spike_in_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .SLACK (SLACK)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .WR_VALID (wr_valid),
    .WR_DATA  (wr_data),
    .BP       (bp),
    .RD_VALID (rd_valid),
    .RD_DATA  (rd_data),
    .RD_READY (rd_ready),
    .LEVEL    (level),
    .OVF      (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_ovf   = 1'b0;
    m_bp    = 1'b0;
    m_armed = 1'b0;
    m_last  = 16'h0000;
  endtask

  task automatic model_edge(input bit wv, input logic [15:0] wd, input bit rr);
    bit pop;
    pop = (mq.size() != 0) && rr;
    if (pop) m_last = mq.pop_front();
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(wd);
      else m_ovf = 1'b1;
    end
    m_pend  = wv && m_armed;
    m_armed = 1'b1;
    m_bp    = (mq.size() + int'(m_pend)) >= int'(DEPTH - SLACK);
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : m_last;
    check_eq({tag, ".rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    check_eq({tag, ".rd_data"},  32'(rd_data),  32'(exp_data));
    check_eq({tag, ".level"},    32'(level),    mq.size());
    check_eq({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
    check_eq({tag, ".bp"},       32'(bp),       32'(m_bp));
  endtask

  // Called at posedge+1; drives inputs, waits one edge, updates model, checks.
  task automatic tick(input bit wv, input logic [15:0] wd, input bit rr, input string tag);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(posedge clk);
    model_edge(wv, wd, rr);
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    #2;
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    check_eq({tag, ".async_level0"}, 32'(level), 0);
    @(posedge clk);
    #1;
    check_outputs({tag, ".hold"});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wv;
    bit rr;
    int max_lvl;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 16'h0000;
    rd_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b0, 16'h0000, 1'b0, "idle");

    // Single write then pop.
    tick(1'b1, 16'h0000, 1'b0, "w1_pulse");
    tick(1'b0, 16'hA5C3, 1'b0, "w1_commit");
    check_eq("w1_valid", 32'(rd_valid), 1);
    check_eq("w1_data", 32'(rd_data), 32'h0000_A5C3);
    check_eq("w1_level", 32'(level), 1);
    tick(1'b0, 16'h0000, 1'b1, "w1_pop");
    check_eq("w1_empty", 32'(rd_valid), 0);
    check_eq("w1_hold", 32'(rd_data), 32'h0000_A5C3);

    // Ordering and wrap with alternate-cycle pops.
    max_lvl = 0;
    for (int k = 0; k <= 6; k++) begin
      tick(k < 6, 16'(k), k[0], "order");
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    for (int k = 0; k < 6; k++) tick(1'b0, 16'h0000, 1'b1, "order_drain");
    check_eq("order_maxlvl", 32'(max_lvl), 4);
    check_eq("order_ovf", 32'(ovf), 0);

    // Backpressure threshold and release.
    tick(1'b1, 16'h0000, 1'b0, "bp_p1");
    tick(1'b1, 16'h0B01, 1'b0, "bp_p2");
    tick(1'b0, 16'h0B02, 1'b0, "bp_c2");
    check_eq("bp_level2", 32'(level), 2);
    check_eq("bp_high", 32'(bp), 1);
    tick(1'b0, 16'h0000, 1'b1, "bp_pop");
    check_eq("bp_low", 32'(bp), 0);
    tick(1'b0, 16'h0000, 1'b1, "bp_drain");

    // Overflow: five writes, no reads.
    for (int k = 0; k <= 5; k++) tick(k < 5, 16'h0C00 + 16'(k), 1'b0, "ovf_fill");
    check_eq("ovf_level", 32'(level), 4);
    check_eq("ovf_flag", 32'(ovf), 1);
    check_eq("ovf_head", 32'(rd_data), 32'h0000_0C01);
    for (int k = 0; k < 5; k++) tick(1'b0, 16'h0000, 1'b1, "ovf_drain");
    check_eq("ovf_sticky", 32'(ovf), 1);
    apply_reset("rst1");
    tick(1'b0, 16'h0000, 1'b0, "rst1_idle");

    // Full with simultaneous commit and pop.
    for (int k = 0; k <= 4; k++) tick(k < 4, 16'h0D00 + 16'(k), 1'b0, "full_fill");
    tick(1'b1, 16'h0000, 1'b0, "full_pulse");
    tick(1'b0, 16'hBEEF, 1'b1, "full_commit_pop");
    check_eq("full_level", 32'(level), 4);
    check_eq("full_ovf", 32'(ovf), 0);
    for (int k = 0; k < 3; k++) tick(1'b0, 16'h0000, 1'b1, "full_drain");
    check_eq("full_last", 32'(rd_data), 32'h0000_BEEF);
    tick(1'b0, 16'h0000, 1'b1, "full_final");

    // Reset mid-stream with a pending write.
    for (int k = 0; k <= 3; k++) tick(1'b1, 16'h0E00 + 16'(k), 1'b0, "mid_fill");
    check_eq("mid_level3", 32'(level), 3);
    apply_reset("rst2");
    tick(1'b1, 16'hDEAD, 1'b0, "rst2_ignored_pulse");
    tick(1'b0, 16'hDEAD, 1'b0, "rst2_ignored_data");
    check_eq("rst2_level0", 32'(level), 0);
    tick(1'b1, 16'h0000, 1'b0, "rst2_pulse");
    tick(1'b0, 16'h1234, 1'b0, "rst2_commit");
    check_eq("rst2_data", 32'(rd_data), 32'h0000_1234);
    tick(1'b0, 16'h0000, 1'b1, "rst2_pop");

    // Random traffic ignoring backpressure.
    for (int k = 0; k < 300; k++) begin
      wv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) == 0);
      tick(wv, 16'($urandom), rr, "rand_free");
    end
    apply_reset("rst3");

    // Random traffic from an upstream that honours BP.
    for (int k = 0; k < 400; k++) begin
      wv = !m_bp && ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 2) == 0);
      tick(wv, 16'($urandom), rr, "rand_comp");
    end
    check_eq("comp_no_ovf", 32'(ovf), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
